// File: rtl/merge_pkg.sv
// rtl/merge_pkg.sv - shared types and constants for the lane merge/split datapath
//
// Purpose: common definitions used by split_fifo, lane_fifo and the merge stage.
//   split_state_e : RUN accepts elements, FLUSH closes a list in every lane
//   entry_t       : lane FIFO entry {last, empty, data} at the default data width
//   lane_count()  : number of lanes addressed by a tag of the given width
// Ports: none (package).
package merge_pkg;

  localparam int ELEM_DW = 8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } split_state_e;

  // Lane FIFO entry. Modules with a non-default data width use the same
  // layout as a flat vector: last at the MSB, empty below it, data below.
  typedef struct packed {
    logic               last;
    logic               empty;
    logic [ELEM_DW-1:0] data;
  } entry_t;

  function automatic int lane_count(input int thw);
    return 1 << thw;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - show-ahead synchronous FIFO used as one split_fifo output lane
//
// Purpose: single-clock FIFO whose head entry is visible whenever valid_o is high.
// Ports:
//   clk, reset  : clock and synchronous active-high reset (empties the FIFO)
//   push_i      : write wdata_i this cycle (caller guarantees space or a same-cycle pop)
//   wdata_i     : entry to write, W bits
//   pop_i       : consumer takes the head; ignored while empty
//   valid_o     : FIFO holds at least one entry
//   rdata_o     : head entry
//   count_o     : occupancy, AW+1 bits so that a full FIFO is distinguishable
module lane_fifo #(
  parameter int W  = 10,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   count_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_pop;

  assign do_pop = pop_i && valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Push and pop together leave the occupancy unchanged, even when full.
    if (push_i && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_i && do_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/split_fifo.sv
// rtl/split_fifo.sv - splits a lane-tagged merged stream into per-lane last-terminated lists
//
// Purpose: routes each accepted element to the FIFO of lane i_th. Each lane holds
// back its newest element so that, when the merged list ends, that element can be
// tagged last; lanes that received nothing in the list emit an empty-list marker.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   i_valid    : input element valid
//   i_ready    : element accepted when i_valid && i_ready
//   i_last     : final element of the merged list
//   i_data     : element value, DW bits
//   i_th       : destination lane, THW bits
//   o_valid    : per-lane entry valid (NL bits)
//   o_ready    : per-lane consumer ready (NL bits)
//   o_last     : per-lane entry closes the list
//   o_empty    : per-lane entry is an empty-list marker (only with o_last)
//   o_data     : lane k on bits [k*DW +: DW]; zero for markers and idle lanes
module split_fifo import merge_pkg::*; #(
  parameter  int DW               = ELEM_DW,
  parameter  int THW              = 2,
  parameter  int FIFO_DEPTH_WIDTH = 8,
  localparam int NL               = lane_count(THW)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic             i_last,
  input  logic [DW-1:0]    i_data,
  input  logic [THW-1:0]   i_th,
  output logic [NL-1:0]    o_valid,
  input  logic [NL-1:0]    o_ready,
  output logic [NL-1:0]    o_last,
  output logic [NL-1:0]    o_empty,
  output logic [NL*DW-1:0] o_data
);

  localparam int AW = FIFO_DEPTH_WIDTH;
  localparam int EW = DW + 2;

  split_state_e  state_q;
  logic [NL-1:0] held_v_q;
  logic [DW-1:0] held_d_q [NL];

  logic [NL-1:0] has_space;
  logic [NL-1:0] push;
  logic [NL-1:0] pop;
  logic [NL-1:0] fifo_valid;
  logic [EW-1:0] push_entry [NL];
  logic [EW-1:0] fifo_head  [NL];
  logic [AW:0]   fifo_count [NL];

  logic all_space;
  logic accept;
  logic flush_go;

  // Any single full lane stalls the whole input (head-of-line coupling).
  assign all_space = &has_space;
  assign i_ready   = !reset && (state_q == RUN) && all_space;
  assign accept    = i_valid && i_ready;
  assign flush_go  = (state_q == FLUSH) && all_space;

  for (genvar k = 0; k < NL; k++) begin : g_lane
    // Count never exceeds DEPTH, so its MSB is set exactly when the lane is full.
    assign has_space[k] = !fifo_count[k][AW];

    always_comb begin
      push[k]       = 1'b0;
      push_entry[k] = '0;
      if (flush_go) begin
        push[k] = 1'b1;
        if (held_v_q[k]) begin
          push_entry[k] = {1'b1, 1'b0, held_d_q[k]};
        end else begin
          push_entry[k] = {1'b1, 1'b1, {DW{1'b0}}};
        end
      end else if (accept && (i_th == THW'(k)) && held_v_q[k]) begin
        // A newer element arrived, so the held one is known not to be last.
        push[k]       = 1'b1;
        push_entry[k] = {1'b0, 1'b0, held_d_q[k]};
      end
    end

    assign pop[k] = fifo_valid[k] && o_ready[k];

    lane_fifo #(
      .W  (EW),
      .AW (AW)
    ) u_lane_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[k]),
      .wdata_i (push_entry[k]),
      .pop_i   (pop[k]),
      .valid_o (fifo_valid[k]),
      .rdata_o (fifo_head[k]),
      .count_o (fifo_count[k])
    );

    // Idle lanes drive zeros rather than stale FIFO storage.
    assign o_valid[k]          = fifo_valid[k];
    assign o_last[k]           = fifo_valid[k] && fifo_head[k][DW+1];
    assign o_empty[k]          = fifo_valid[k] && fifo_head[k][DW];
    assign o_data[k*DW +: DW]  = fifo_valid[k] ? fifo_head[k][DW-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      held_v_q <= '0;
      for (int k = 0; k < NL; k++) begin
        held_d_q[k] <= '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            held_v_q[i_th] <= 1'b1;
            held_d_q[i_th] <= i_data;
            if (i_last) begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_go) begin
            held_v_q <= '0;
            state_q  <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_split_fifo.sv
// tb/tb_split_fifo.sv - self-checking bench for split_fifo
module tb_split_fifo;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        i_ready;
  logic        i_last;
  logic [7:0]  i_data;
  logic [1:0]  i_th;
  logic [3:0]  o_valid;
  logic [3:0]  o_ready;
  logic [3:0]  o_last;
  logic [3:0]  o_empty;
  logic [31:0] o_data;

  int checks = 0;
  int errors = 0;

  split_fifo #(.DW(8), .THW(2), .FIFO_DEPTH_WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_last  (i_last),
    .i_data  (i_data),
    .i_th    (i_th),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_last  (o_last),
    .o_empty (o_empty),
    .o_data  (o_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: each lane's expected output is its list elements in
  // arrival order, the last one flagged, or a single marker for an empty list.
  typedef struct packed {
    logic       last;
    logic       empty;
    logic [7:0] data;
  } ent_t;

  ent_t exp_q [4][$];
  bit   got_elem [4];
  ent_t m_act, m_exp, m_tmp;

  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        exp_q[k].delete();
        got_elem[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (o_valid[k] && o_ready[k]) begin
          m_act = '{o_last[k], o_empty[k], o_data[k*8 +: 8]};
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL lane%0d_unexpected got=%0h exp=none", k, m_act);
          end else begin
            m_exp = exp_q[k].pop_front();
            if (m_act !== m_exp) begin
              errors++;
              $display("FAIL lane%0d_entry got=%0h exp=%0h", k, m_act, m_exp);
            end
          end
        end
        if (!o_valid[k]) begin
          chk($sformatf("lane%0d_idle_zero", k), {22'd0, o_last[k], o_empty[k], o_data[k*8 +: 8]}, 32'd0);
        end
      end
      if (i_valid && i_ready) begin
        exp_q[i_th].push_back('{1'b0, 1'b0, i_data});
        got_elem[i_th] = 1'b1;
        if (i_last) begin
          for (int k = 0; k < 4; k++) begin
            if (got_elem[k]) begin
              if (exp_q[k].size() > 0) begin
                m_tmp = exp_q[k].pop_back();
                m_tmp.last = 1'b1;
                exp_q[k].push_back(m_tmp);
              end
            end else begin
              exp_q[k].push_back('{1'b1, 1'b1, 8'h00});
            end
            got_elem[k] = 1'b0;
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] th, input logic last);
    int w;
    w = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_th    = th;
    i_last  = last;
    @(negedge clk);
    while (!i_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (!i_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=stalled exp=accepted");
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    int pending;
    w = 0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    o_ready = 4'hf;
    do begin
      @(negedge clk);
      #1;
      pending = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
      w++;
    end while ((pending != 0 || o_valid != 4'h0) && w < 1000);
    chk({name, "_pending"}, pending, 0);
    chk({name, "_ovalid"}, {28'd0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic        l;
    logic [7:0]  d;
    logic [1:0]  th;
    logic        rdy;
    logic [3:0]  ov;
    logic [3:0]  ol;
    logic [3:0]  oe;
    logic [31:0] od;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Basic split followed by the single-beat lane3 list.
    tbl[0]  = '{1'b1, 1'b0, 8'h02, 2'd0, 1'b1, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 8'h03, 2'd1, 1'b1, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 8'h04, 2'd0, 1'b1, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 8'h0d, 2'd2, 1'b1, 4'h1, 4'h0, 4'h0, 32'h00000002};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 4'hf, 4'hf, 4'h8, 32'h000d0304};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 8'h7f, 2'd3, 1'b1, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 4'h0, 4'h0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 4'hf, 4'hf, 4'h7, 32'h7f000000};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 4'h0, 4'h0, 4'h0, 32'h0};

    reset   = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = 8'h00;
    i_th    = 2'd0;
    o_ready = 4'hf;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_iready", {31'd0, i_ready}, 32'd0);
    chk("rst_ovalid", {28'd0, o_valid}, 32'd0);
    chk("rst_olast",  {28'd0, o_last},  32'd0);
    chk("rst_oempty", {28'd0, o_empty}, 32'd0);
    chk("rst_odata",  o_data,           32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int r = 0; r < 11; r++) begin
      i_valid = tbl[r].v;
      i_last  = tbl[r].l;
      i_data  = tbl[r].d;
      i_th    = tbl[r].th;
      @(negedge clk);
      chk($sformatf("tbl%0d_iready", r), {31'd0, i_ready}, {31'd0, tbl[r].rdy});
      chk($sformatf("tbl%0d_ovalid", r), {28'd0, o_valid}, {28'd0, tbl[r].ov});
      chk($sformatf("tbl%0d_olast",  r), {28'd0, o_last},  {28'd0, tbl[r].ol});
      chk($sformatf("tbl%0d_oempty", r), {28'd0, o_empty}, {28'd0, tbl[r].oe});
      chk($sformatf("tbl%0d_odata",  r), o_data, tbl[r].od);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    drain("basic");

    // Back-to-back lists: six beats on lane1, then a single beat on lane3.
    for (int j = 0; j < 6; j++) begin
      send(8'h10 + 8'(j * 4), 2'd1, (j == 5));
    end
    send(8'h28, 2'd3, 1'b1);
    drain("b2b");

    // Full lane: lane0 blocked until DEPTH+2 elements are offered.
    o_ready = 4'b1110;
    for (int j = 0; j < DEPTH + 1; j++) begin
      send(8'(j), 2'd0, 1'b0);
    end
    i_valid = 1'b1;
    i_data  = 8'ha5;
    i_th    = 2'd0;
    i_last  = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("full_iready_low", {31'd0, i_ready}, 32'd0);
      chk("full_other_lanes", {28'd0, o_valid & 4'b1110}, 32'd0);
    end
    chk("full_lane0_valid", {31'd0, o_valid[0]}, 32'd1);
    @(posedge clk);
    #1;
    o_ready = 4'hf;
    send(8'ha5, 2'd0, 1'b1);
    drain("full");

    // FLUSH blocked: lane2 becomes full exactly on the i_last beat.
    o_ready = 4'b1011;
    for (int j = 0; j < DEPTH; j++) begin
      send(8'(j + 3), 2'd2, 1'b0);
    end
    send(8'hee, 2'd2, 1'b1);
    o_ready = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("flushblk_iready", {31'd0, i_ready}, 32'd0);
      chk("flushblk_no_push", {28'd0, o_valid & 4'b1011}, 32'd0);
    end
    @(posedge clk);
    #1;
    o_ready = 4'b0100;
    @(posedge clk);
    #1;
    o_ready = 4'b0000;
    @(negedge clk);
    chk("flushblk_before", {28'd0, o_valid & 4'b1011}, 32'd0);
    @(negedge clk);
    chk("flushblk_all_valid", {28'd0, o_valid}, 32'hf);
    chk("flushblk_markers", {28'd0, o_empty & o_last}, 32'hb);
    drain("flushblk");

    // Reset in the middle of a list.
    send(8'h31, 2'd0, 1'b0);
    send(8'h32, 2'd1, 1'b0);
    send(8'h33, 2'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ovalid", {28'd0, o_valid}, 32'd0);
    @(posedge clk);
    #1;
    send(8'h05, 2'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_valid", {28'd0, o_valid}, 32'hf);
    chk("midrst_empty", {28'd0, o_empty}, 32'he);
    chk("midrst_data", o_data, 32'h00000005);
    drain("midrst");

    // Randomised traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      i_valid = ($urandom_range(0, 9) < 7);
      i_th    = 2'($urandom_range(0, 3));
      i_data  = 8'($urandom);
      i_last  = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 4; k++) begin
        o_ready[k] = ($urandom_range(0, 9) < 7);
      end
    end
    @(posedge clk);
    #1;
    o_ready = 4'hf;
    send(8'h55, 2'd1, 1'b1);
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
